libv_csa_acc_seq: RTL and testbench

Multi-beat accumulation sequencer around the libv_csa compression network. Accepts a stream of K-word beats forming a group (terminated by in_last) and keeps a running carry/save pair. Each beat is folded in through one CSA pass, so there is no carry propagation per beat. At group end it performs a single carry-propagate add and presents the W-bit sum with a beat count on a valid/ready output. Used wherever long operand lists (dot-product partials, checksum lanes) must be summed at one beat per cycle.

---
 rtl/libv_csa_acc_seq.sv | 143 ++++++++++++++
 tb/tb_libv_csa_acc_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/libv_csa_acc_seq.sv
// libv_csa_acc_seq: multi-beat accumulation sequencer.
// Each accepted beat of K words is folded into a redundant carry/save pair by
// a combinational 3:2 compressor chain (no carry propagation per beat). When
// the beat flagged in_last has been folded in, one carry-propagate add
// resolves the pair, and the W-bit sum is presented with the beat count on a
// valid/ready output. All arithmetic is modulo 2^W.
module libv_csa_acc_seq #(
    parameter int W     = 32,
    parameter int K     = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    input  logic [K-1:0][W-1:0]   in_x,
    input  logic                  in_last,
    output logic                  in_rdy,
    output logic                  out_vld,
    output logic [W-1:0]          out_sum,
    output logic [CNT_W-1:0]      out_cnt,
    input  logic                  out_rdy,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_ACC     = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_OUT     = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [W-1:0]     r_s;
    logic [W-1:0]     r_c;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_out_sum;
    logic [CNT_W-1:0] r_out_cnt;

    logic             w_accept;
    logic             w_resolve;
    logic             w_clear;

    // Save/carry rows after each compressor stage; index 0 is the stored pair.
    logic [W-1:0]     w_s_chain [0:K];
    logic [W-1:0]     w_c_chain [0:K];

    // Majority of three words shifted up one bit; the carry out of bit W-1
    // falls off the top, which is exactly the modulo-2^W behaviour we want.
    function automatic logic [W-1:0] csa_carry(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic [W-1:0] c);
        logic [W-1:0] maj;
        maj = (a & b) | (a & c) | (b & c);
        return maj << 1;
    endfunction

    // Beat counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        else
            return v + CNT_W'(1);
    endfunction

    assign w_s_chain[0] = r_s;
    assign w_c_chain[0] = r_c;

    for (genvar g = 0; g < K; g++) begin : g_csa
        assign w_s_chain[g+1] = w_s_chain[g] ^ w_c_chain[g] ^ in_x[g];
        assign w_c_chain[g+1] = csa_carry(w_s_chain[g], w_c_chain[g], in_x[g]);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_ACC;
        else
            r_state <= w_state_nxt;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_rdy      = 1'b0;
        out_vld     = 1'b0;
        w_accept    = 1'b0;
        w_resolve   = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_ACC: begin
                in_rdy = 1'b1;
                if (in_vld) begin
                    w_accept = 1'b1;
                    if (in_last)
                        w_state_nxt = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                w_resolve   = 1'b1;
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                out_vld = 1'b1;
                if (out_rdy) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_ACC;
                end
            end
            default: w_state_nxt = ST_ACC;
        endcase
    end

    // Accumulator pair, beat counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s       <= '0;
            r_c       <= '0;
            r_cnt     <= '0;
            r_out_sum <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_s   <= w_s_chain[K];
                r_c   <= w_c_chain[K];
                r_cnt <= sat_inc(r_cnt);
            end else if (w_clear) begin
                r_s   <= '0;
                r_c   <= '0;
                r_cnt <= '0;
            end
            if (w_resolve) begin
                r_out_sum <= r_s + r_c;
                r_out_cnt <= r_cnt;
            end
        end
    end

    assign out_sum = r_out_sum;
    assign out_cnt = r_out_cnt;
    assign busy    = (r_state != ST_ACC) || (r_cnt != '0);

endmodule

// File: tb/tb_libv_csa_acc_seq.sv
// Self-checking bench for libv_csa_acc_seq: a latency-based behavioural model
// predicts every output on every cycle, and directed groups pin literal sums.
module tb_libv_csa_acc_seq;

    localparam int W     = 32;
    localparam int K     = 4;
    localparam int CNT_W = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_vld = 1'b0;
    logic [K-1:0][W-1:0]   in_x = '0;
    logic                  in_last = 1'b0;
    logic                  in_rdy;
    logic                  out_vld;
    logic [W-1:0]          out_sum;
    logic [CNT_W-1:0]      out_cnt;
    logic                  out_rdy = 1'b0;
    logic                  busy;

    libv_csa_acc_seq #(.W(W), .K(K), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_x    (in_x),
        .in_last (in_last),
        .in_rdy  (in_rdy),
        .out_vld (out_vld),
        .out_sum (out_sum),
        .out_cnt (out_cnt),
        .out_rdy (out_rdy),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] word_sum(input logic [K-1:0][W-1:0] x);
        logic [W-1:0] acc;
        acc = '0;
        for (int k = 0; k < K; k++) acc = acc + x[k];
        return acc;
    endfunction

    function automatic logic [K-1:0][W-1:0] rnd_beat();
        logic [K-1:0][W-1:0] r;
        for (int k = 0; k < K; k++) r[k] = $urandom;
        return r;
    endfunction

    // Behavioural model: a group is "closed" once its last beat is taken;
    // the result is visible two cycles later and stays until handshake.
    bit               chk_en = 1'b0;
    int               m_cyc = 0;
    bit               m_closed = 1'b0;
    int               m_vld_cyc = 0;
    logic [W-1:0]     m_sum = '0;
    int               m_cnt = 0;
    logic [W-1:0]     m_res_sum = '0;
    int               m_res_cnt = 0;
    logic [W-1:0]     m_vis_sum = '0;
    int               m_vis_cnt = 0;
    localparam int    CNT_MAX = (1 << CNT_W) - 1;

    always @(negedge clk) begin
        bit exp_vld;
        if (chk_en) begin
            exp_vld = m_closed && (m_cyc >= m_vld_cyc);
            if (m_closed && m_cyc == m_vld_cyc) begin
                m_vis_sum = m_res_sum;
                m_vis_cnt = m_res_cnt;
            end
            cmp("in_rdy",  64'(in_rdy),  64'(!m_closed));
            cmp("out_vld", 64'(out_vld), 64'(exp_vld));
            cmp("busy",    64'(busy),    64'(m_closed || m_cnt != 0));
            cmp("out_sum", 64'(out_sum), 64'(m_vis_sum));
            cmp("out_cnt", 64'(out_cnt), 64'(m_vis_cnt));
            if (rst) begin
                m_closed  = 1'b0;
                m_sum     = '0;
                m_cnt     = 0;
                m_vis_sum = '0;
                m_vis_cnt = 0;
            end else if (!m_closed) begin
                if (in_vld) begin
                    m_sum = m_sum + word_sum(in_x);
                    if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
                    if (in_last) begin
                        m_closed  = 1'b1;
                        m_vld_cyc = m_cyc + 2;
                        m_res_sum = m_sum;
                        m_res_cnt = m_cnt;
                    end
                end
            end else if (exp_vld && out_rdy) begin
                m_closed = 1'b0;
                m_sum    = '0;
                m_cnt    = 0;
            end
            m_cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [K-1:0][W-1:0] x, input logic last);
        bit acc;
        int t;
        acc = 1'b0;
        t = 0;
        in_vld  = 1'b1;
        in_x    = x;
        in_last = last;
        while (!acc && t < 100) begin
            @(negedge clk);
            acc = in_rdy;
            tick();
            t++;
        end
        if (!acc) cmp("beat_accept_timeout", 64'(0), 64'(1));
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic get_result(output logic [W-1:0] s, output logic [CNT_W-1:0] c,
                              input bit rand_rdy);
        bit got;
        int t;
        got = 1'b0;
        t = 0;
        s = '0;
        c = '0;
        while (!got && t < 200) begin
            out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (out_vld && out_rdy) begin
                got = 1'b1;
                s = out_sum;
                c = out_cnt;
            end
            tick();
            t++;
        end
        if (!got) cmp("result_timeout", 64'(0), 64'(1));
        out_rdy = 1'b0;
    endtask

    task automatic wait_out_vld();
        int t;
        t = 0;
        @(negedge clk);
        while (!out_vld && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!out_vld) cmp("out_vld_timeout", 64'(0), 64'(1));
        tick();
    endtask

    initial begin
        logic [K-1:0][W-1:0] x;
        logic [W-1:0]        s;
        logic [CNT_W-1:0]    c;
        bit                  acc;
        int                  len;

        // Reset
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        cmp("rst_out_vld", 64'(out_vld), 64'(0));
        cmp("rst_busy",    64'(busy),    64'(0));
        cmp("rst_out_sum", 64'(out_sum), 64'(0));
        cmp("rst_in_rdy",  64'(in_rdy),  64'(1));
        rst = 1'b0;
        tick();

        // Single beat
        x = '0; x[0] = 1; x[1] = 2; x[2] = 3; x[3] = 4;
        beat(x, 1'b1);
        get_result(s, c, 1'b0);
        cmp("single_sum", 64'(s), 64'(10));
        cmp("single_cnt", 64'(c), 64'(1));

        // Three beats
        for (int b = 1; b <= 3; b++) begin
            for (int k = 0; k < K; k++) x[k] = W'(b);
            beat(x, b == 3);
        end
        get_result(s, c, 1'b0);
        cmp("three_sum", 64'(s), 64'(24));
        cmp("three_cnt", 64'(c), 64'(3));

        // Wrap
        x[0] = 32'hFFFF_FFFF; x[1] = 32'hFFFF_FFFF; x[2] = 2; x[3] = 0;
        beat(x, 1'b1);
        get_result(s, c, 1'b0);
        cmp("wrap_sum", 64'(s), 64'(0));
        cmp("wrap_cnt", 64'(c), 64'(1));

        // Backpressure
        x = '0; x[0] = 32'h1234; x[2] = 32'h10;
        out_rdy = 1'b0;
        beat(x, 1'b1);
        wait_out_vld();
        repeat (5) tick();
        @(negedge clk);
        cmp("bp_in_rdy",  64'(in_rdy),  64'(0));
        cmp("bp_out_vld", 64'(out_vld), 64'(1));
        cmp("bp_out_sum", 64'(out_sum), 64'(32'h1244));
        tick();
        get_result(s, c, 1'b0);
        cmp("bp_sum", 64'(s), 64'(32'h1244));
        x = '0; x[0] = 5;
        beat(x, 1'b1);
        get_result(s, c, 1'b0);
        cmp("after_bp_sum", 64'(s), 64'(5));

        // Reset mid-group
        for (int k = 0; k < K; k++) x[k] = 9;
        beat(x, 1'b0);
        beat(x, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        cmp("midrst_busy",    64'(busy),    64'(0));
        cmp("midrst_out_vld", 64'(out_vld), 64'(0));
        tick();
        x = '0; x[0] = 7;
        beat(x, 1'b1);
        get_result(s, c, 1'b0);
        cmp("midrst_sum", 64'(s), 64'(7));
        cmp("midrst_cnt", 64'(c), 64'(1));

        // Reset while a result is pending
        x = '0; x[1] = 33;
        beat(x, 1'b1);
        wait_out_vld();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        cmp("pendrst_out_vld", 64'(out_vld), 64'(0));
        cmp("pendrst_out_sum", 64'(out_sum), 64'(0));
        tick();

        // Back-to-back single-beat groups
        out_rdy = 1'b1;
        in_vld  = 1'b1;
        in_last = 1'b1;
        in_x    = rnd_beat();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            acc = in_rdy;
            tick();
            if (acc) in_x = rnd_beat();
        end
        in_vld  = 1'b0;
        in_last = 1'b0;
        repeat (4) tick();
        out_rdy = 1'b0;

        // Counter saturation
        for (int b = 0; b < 20; b++) beat(rnd_beat(), b == 19);
        get_result(s, c, 1'b0);
        cmp("sat_cnt", 64'(c), 64'(CNT_MAX));

        // Random groups, idle gaps with stray in_last, random out_rdy
        for (int g = 0; g < 25; g++) begin
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 2)) begin
                    in_last = 1'($urandom_range(0, 1));
                    tick();
                end
                beat(rnd_beat(), b == len - 1);
            end
            get_result(s, c, 1'b1);
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
